// File: rtl/calculadora_pkg.sv
// Shared constants for the calculator: default width, opcodes and the
// sequencer state encoding.
package calculadora_pkg;

   localparam int LARGURA_PADRAO = 8;

   localparam logic [2:0] OP_ZERA = 3'b000;
   localparam logic [2:0] OP_A    = 3'b001;
   localparam logic [2:0] OP_B    = 3'b010;
   localparam logic [2:0] OP_SOMA = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;

   typedef enum logic [2:0] {
      RECEBE_A,
      RECEBE_B,
      RECEBE_OP,
      EXECUTA,
      ENTREGA
   } estado_t;

endpackage

// File: rtl/calculadora_sequenciador.sv
// Byte-stream front end for the combinational calculator core: collects A, B
// and opcode, samples the core result one cycle later and hands it out.
module calculadora_sequenciador
   import calculadora_pkg::*;
#(
   parameter int LARGURA = LARGURA_PADRAO
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [LARGURA-1:0] entrada_dado,
   input  logic               entrada_valida,
   output logic               entrada_pronta,
   output logic [LARGURA-1:0] calc_A,
   output logic [LARGURA-1:0] calc_B,
   output logic [2:0]         calc_codigo,
   input  logic [LARGURA-1:0] calc_saida,
   output logic [LARGURA-1:0] resultado,
   output logic               resultado_valido,
   input  logic               resultado_pronto,
   output logic               erro,
   output logic [7:0]         contador_ops
);

   estado_t estado;

   // Ready is a pure function of state, gated by reset so nothing is taken
   // in the cycle the sequencer is being cleared.
   assign entrada_pronta = !rst &&
                           (estado == RECEBE_A || estado == RECEBE_B || estado == RECEBE_OP);

   always_ff @(posedge clk) begin
      if (rst) begin
         estado           <= RECEBE_A;
         calc_A           <= '0;
         calc_B           <= '0;
         calc_codigo      <= '0;
         resultado        <= '0;
         erro             <= 1'b0;
         resultado_valido <= 1'b0;
         contador_ops     <= '0;
      end else begin
         case (estado)
            RECEBE_A: begin
               if (entrada_valida) begin
                  calc_A <= entrada_dado;
                  estado <= RECEBE_B;
               end
            end
            RECEBE_B: begin
               if (entrada_valida) begin
                  calc_B <= entrada_dado;
                  estado <= RECEBE_OP;
               end
            end
            RECEBE_OP: begin
               if (entrada_valida) begin
                  calc_codigo <= entrada_dado[2:0];
                  estado      <= EXECUTA;
               end
            end
            EXECUTA: begin
               resultado        <= calc_saida;
               erro             <= (calc_codigo > OP_SUB);
               resultado_valido <= 1'b1;
               estado           <= ENTREGA;
            end
            ENTREGA: begin
               if (resultado_pronto) begin
                  resultado_valido <= 1'b0;
                  contador_ops     <= contador_ops + 8'd1;
                  estado           <= RECEBE_A;
               end
            end
            default: estado <= RECEBE_A;
         endcase
      end
   end

endmodule
